// File: rtl/boot_loader.sv
// Byte-stream boot loader: 4-byte LE word-count header, then program bytes packed into 32-bit word writes.
// Optional BOOT_CLEAR_EN zero-fills the whole memory before the header is accepted.
module boot_loader #(
  parameter int unsigned MEM_WORDS = 1048576,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        mem_WE,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_data,
  output logic        core_hold,
  output logic        done,
  output logic        err,
  output logic [31:0] loaded_words
);

`ifdef BOOT_CLEAR_EN
  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_HDR, S_LOAD, S_DONE, S_ERR} state_t;
  logic [31:0] r_clr;
`else
  typedef enum logic [2:0] {S_IDLE, S_HDR, S_LOAD, S_DONE, S_ERR} state_t;
`endif

  state_t      r_state;
  logic [1:0]  r_idx;
  logic [23:0] r_buf;
  logic [31:0] r_hdr;
  logic        w_xfer;
  logic [31:0] w_word;
  logic [31:0] w_next_lw;

  assign w_xfer    = in_valid & in_ready;
  assign w_word    = {in_data, r_buf};
  assign w_next_lw = loaded_words + 32'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_idx        <= 2'd0;
      r_buf        <= 24'd0;
      r_hdr        <= 32'd0;
      in_ready     <= 1'b0;
      mem_WE       <= 1'b0;
      mem_addr     <= 32'd0;
      mem_data     <= 32'd0;
      core_hold    <= 1'b1;
      done         <= 1'b0;
      err          <= 1'b0;
      loaded_words <= 32'd0;
`ifdef BOOT_CLEAR_EN
      r_clr        <= 32'd0;
`endif
    end else begin
      mem_WE <= 1'b0;
      // Header and payload share the byte index and partial-word buffer.
      if (w_xfer) begin
        r_idx <= r_idx + 2'd1;
        case (r_idx)
          2'd0:    r_buf[7:0]   <= in_data;
          2'd1:    r_buf[15:8]  <= in_data;
          2'd2:    r_buf[23:16] <= in_data;
          default: ;
        endcase
      end
      case (r_state)
        S_IDLE: if (start) begin
`ifdef BOOT_CLEAR_EN
          r_state <= S_CLEAR;
          r_clr   <= 32'd0;
`else
          r_state  <= S_HDR;
          in_ready <= 1'b1;
`endif
        end
`ifdef BOOT_CLEAR_EN
        S_CLEAR: begin
          mem_WE   <= 1'b1;
          mem_addr <= BASE_ADDR + (r_clr << 2);
          mem_data <= 32'd0;
          if (r_clr == 32'(MEM_WORDS - 1)) begin
            r_state  <= S_HDR;
            in_ready <= 1'b1;
          end else begin
            r_clr <= r_clr + 32'd1;
          end
        end
`endif
        S_HDR: if (w_xfer && r_idx == 2'd3) begin
          r_hdr <= w_word;
          if (w_word == 32'd0) begin
            r_state   <= S_DONE;
            in_ready  <= 1'b0;
            done      <= 1'b1;
            core_hold <= 1'b0;
          end else if (w_word > 32'(MEM_WORDS)) begin
            r_state  <= S_ERR;
            in_ready <= 1'b0;
            err      <= 1'b1;
          end else begin
            r_state <= S_LOAD;
          end
        end
        S_LOAD: begin
          // in_ready low here means the final word is being written this cycle.
          if (!in_ready) begin
            r_state   <= S_DONE;
            done      <= 1'b1;
            core_hold <= 1'b0;
          end else if (w_xfer && r_idx == 2'd3) begin
            mem_WE       <= 1'b1;
            mem_addr     <= BASE_ADDR + (loaded_words << 2);
            mem_data     <= w_word;
            loaded_words <= w_next_lw;
            if (w_next_lw == r_hdr) in_ready <= 1'b0;
          end
        end
        S_DONE, S_ERR: ;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_boot_loader.sv
// Scoreboard bench for boot_loader (MEM_WORDS=16): expected writes queued at stimulus time, popped on mem_WE.
module tb_boot_loader;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready, mem_WE, core_hold, done, err;
  logic [31:0] mem_addr, mem_data, loaded_words;

  boot_loader #(.MEM_WORDS(16), .BASE_ADDR(32'h0)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .mem_WE(mem_WE), .mem_addr(mem_addr), .mem_data(mem_data),
    .core_hold(core_hold), .done(done), .err(err), .loaded_words(loaded_words)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] lw;
  } wr_t;

  wr_t q[$];
  int  n_vec = 0;
  int  n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Write monitor: every mem_WE must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst && mem_WE === 1'b1) begin
      if (q.size() == 0) begin
        chk("unexp_we", {31'd0, mem_WE}, 32'd0);
      end else begin
        wr_t e;
        e = q.pop_front();
        chk("wr_addr", mem_addr, e.a);
        chk("wr_data", mem_data, e.d);
        chk("wr_lw", loaded_words, e.lw);
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic pulse_start();
`ifdef BOOT_CLEAR_EN
    for (int i = 0; i < 16; i++) q.push_back('{a: 32'(i * 4), d: 32'd0, lw: 32'd0});
`endif
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  // Returns #1 after the edge at which the byte was accepted.
  task automatic send(input logic [7:0] b, input bit gap);
    int t;
    t = 0;
    if (gap) begin
      @(negedge clk); in_valid = 1'b0;
    end
    @(negedge clk); in_valid = 1'b1; in_data = b;
    while (!in_ready && t < 200) begin
      @(negedge clk); t++;
    end
    if (t >= 200) chk("rdy_timeout", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic send_word(input logic [31:0] w, input bit gap);
    for (int k = 0; k < 4; k++) send(w[8*k +: 8], gap);
  endtask

  task automatic load2(input logic [31:0] w0, input logic [31:0] w1, input bit gap);
    q.push_back('{a: 32'h0, d: w0, lw: 32'd1});
    q.push_back('{a: 32'h4, d: w1, lw: 32'd2});
    send_word(32'd2, gap);
    send_word(w0, gap);
    send_word(w1, gap);
    in_valid = 1'b0;
    chk("last_we", {31'd0, mem_WE}, 32'd1);
    chk("last_rdy", {31'd0, in_ready}, 32'd0);
    chk("last_done_early", {31'd0, done}, 32'd0);
    @(posedge clk); #1;
    chk("done", {31'd0, done}, 32'd1);
    chk("hold", {31'd0, core_hold}, 32'd0);
    chk("done_we", {31'd0, mem_WE}, 32'd0);
    chk("lw", loaded_words, 32'd2);
    chk("q_drained", 32'(q.size()), 32'd0);
  endtask

  initial begin
    do_reset();
    repeat (5) @(negedge clk);
    chk("rst_rdy", {31'd0, in_ready}, 32'd0);
    chk("rst_we", {31'd0, mem_WE}, 32'd0);
    chk("rst_hold", {31'd0, core_hold}, 32'd1);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_lw", loaded_words, 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_data", mem_data, 32'd0);

    pulse_start();
    load2(32'h0000_0513, 32'h0010_0593, 1'b0);

    do_reset();
    pulse_start();
    load2(32'h0000_0513, 32'h0010_0593, 1'b1);

    // Oversized header
    do_reset();
    pulse_start();
    send_word(32'd17, 1'b0);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      chk("err", {31'd0, err}, 32'd1);
      chk("err_rdy", {31'd0, in_ready}, 32'd0);
      chk("err_hold", {31'd0, core_hold}, 32'd1);
    end
    in_valid = 1'b0;
    chk("err_done", {31'd0, done}, 32'd0);

    // Empty image, then a start that must be ignored
    do_reset();
    pulse_start();
    send_word(32'd0, 1'b0);
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("zero_done", {31'd0, done}, 32'd1);
    chk("zero_hold", {31'd0, core_hold}, 32'd0);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (4) @(negedge clk);
    chk("zero_done2", {31'd0, done}, 32'd1);
    chk("zero_rdy", {31'd0, in_ready}, 32'd0);
    chk("zero_lw", loaded_words, 32'd0);

    // Reset mid-load discards the partial word
    do_reset();
    pulse_start();
    send_word(32'd2, 1'b0);
    send(8'hAA, 1'b0);
    send(8'hBB, 1'b0);
    do_reset();
    chk("mid_lw", loaded_words, 32'd0);
    chk("mid_hold", {31'd0, core_hold}, 32'd1);
    pulse_start();
    load2(32'hDEAD_BEEF, 32'h1234_5678, 1'b0);

    repeat (3) @(negedge clk);
    chk("q_final", 32'(q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/boot_loader.md
Name: boot_loader

Overview:
- Upstream feeder of the RV32IM core's byte-lane memory. It replaces hierarchical preloading of the four lane memories with a synthesizable load path.
- Accepts a little-endian byte stream: a 4-byte word-count header followed by program bytes.
- Packs each group of 4 bytes into one 32-bit word and issues a single-cycle word write. Byte i%4 lands in lane i%4, so lane 0 receives the first byte.
- Holds the core stalled via core_hold until the image is fully written.

Parameters:
- MEM_WORDS, 1048576, number of 32-bit words in data/instruction memory (1024*1024 per lane).
- BASE_ADDR, 32'h0000_0000, byte address of the first loaded word; must be 4-aligned.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- start  input  1  single-cycle pulse that begins a load; honoured only in IDLE
- in_valid  input  1  stream byte valid
- in_data  input  8  stream byte
- in_ready  output  1  loader accepts a byte this cycle; a transfer occurs when in_valid && in_ready
- mem_WE  output  1  word write strobe, one cycle per word
- mem_addr  output  32  byte address of the write, always 4-aligned
- mem_data  output  32  {b3,b2,b1,b0}, where b0 is the first byte received
- core_hold  output  1  core stall/reset request; high until load done
- done  output  1  load complete, sticky until rst
- err  output  1  header exceeds MEM_WORDS, sticky until rst
- loaded_words  output  32  count of words written from the stream

Behaviour:
- Reset (rst=1 at a clk edge):
  - State goes to IDLE.
  - Outputs: in_ready=0, mem_WE=0, mem_addr=0, mem_data=0, core_hold=1, done=0, err=0, loaded_words=0.
  - Byte counter, partial word and header are cleared.
  - Reset asserted mid-load discards any partial word. Memory already written is untouched.
- States: IDLE, CLEAR (optional feature only), HDR, LOAD, DONE, ERR.
- IDLE:
  - in_ready=0.
  - start=1 moves to CLEAR if BOOT_CLEAR_EN is defined, otherwise to HDR.
  - start in any other state is ignored.
- HDR:
  - in_ready=1.
  - Collects 4 bytes as N = {b3,b2,b1,b0}.
  - On the 4th accepted byte:
    - N==0 goes to DONE.
    - N>MEM_WORDS goes to ERR.
    - Otherwise goes to LOAD.
- LOAD:
  - in_ready=1 continuously; the loader never back-pressures and memory writes always complete.
  - A 2-bit byte index wraps 3 to 0. Byte k of a word is stored in bits [8k+7:8k].
  - If the 4th byte of word w is accepted at edge t, then during the cycle after t: mem_WE=1, mem_addr=BASE_ADDR+4*w, mem_data = the packed word, and loaded_words=w+1.
  - A new byte may be accepted in that same cycle; it starts word w+1.
  - After word N-1 is accepted, in_ready drops to 0 in the write cycle and the state moves to DONE at the next edge.
- DONE:
  - done=1, core_hold=0, in_ready=0, mem_WE=0.
  - Holds until rst.
  - Latency: the last byte accepted at edge t gives mem_WE in cycle t+1 and done=1/core_hold=0 from cycle t+2.
- ERR:
  - err=1, core_hold=1, in_ready=0.
  - Holds until rst.
- in_valid while in_ready=0: the byte is not consumed.
- in_data is sampled only on a transfer.
- mem_addr and mem_data hold their last values when mem_WE=0.

Optional Feature:
- Macro: BOOT_CLEAR_EN.
- Defined:
  - start moves IDLE to CLEAR.
  - CLEAR writes zero to words 0..MEM_WORDS-1, one per cycle: mem_WE=1, mem_addr=BASE_ADDR+4*i, mem_data=0. This takes MEM_WORDS cycles.
  - in_ready=0 and core_hold=1 throughout; then the state moves to HDR.
  - loaded_words is not incremented by clear writes.
- Undefined:
  - The CLEAR state and its counter are absent.
  - start moves IDLE directly to HDR.
  - Memory is not cleared.

Test Plan (MEM_WORDS=16, BASE_ADDR=0):
- Reset, then idle 5 cycles -> in_ready=0, mem_WE=0, core_hold=1, done=0, err=0, loaded_words=0.
- start; stream 02 00 00 00, 13 05 00 00, 93 05 10 00, with in_valid held high -> two mem_WE pulses: addr 0x0 data 0x00000513, then addr 0x4 data 0x00100593. done=1 and core_hold=0 two cycles after the last byte; loaded_words=2.
- Same stream with in_valid toggling 1,0,1,0 -> identical writes and data. No byte dropped or duplicated.
- Header 11 00 00 00 (N=17) -> err=1, in_ready=0, no mem_WE, core_hold=1 held for 20 cycles.
- Header 00 00 00 00 -> done=1, no mem_WE. Then a start pulse -> no state change.
- Assert rst after 6 bytes of a 2-word load, then redo the full load -> word 0 rewritten and word 1 correct, with no stale bytes. With BOOT_CLEAR_EN defined, 16 zero writes at addr 0x00..0x3C precede header acceptance.
